// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, NOP encoding and the {pc, instr} entry type shared across the IF/ID boundary.
`default_nettype none

package cpu_pkg;

    localparam int CPU_PC_W    = 32;
    localparam int CPU_INSTR_W = 32;

    localparam logic [CPU_INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [CPU_PC_W-1:0]    pc;
        logic [CPU_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/iq_regfile.sv
// iq_regfile: DEPTH-entry storage for the fetch queue; synchronous write, asynchronous read, no reset.
`default_nettype none

module iq_regfile
    import cpu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  ENTRY_T                   wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output ENTRY_T                   rdata_o
);

    ENTRY_T mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : iq_regfile

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: circular {pc, instr} queue between fetch and decode, with flush on redirect.
// Define INSTR_FETCH_QUEUE_BYPASS_EN for a zero-latency path from push to pop when empty.
`default_nettype none

module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PC_W    = CPU_PC_W,
    parameter int INSTR_W = CPU_INSTR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [PC_W-1:0]            push_pc,
    input  logic [INSTR_W-1:0]         push_instr,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [PC_W-1:0]            pop_pc,
    output logic [INSTR_W-1:0]         pop_instr,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW      = $clog2(DEPTH);
    localparam int PTR_W   = AW + 1;
    localparam int ENTRY_W = PC_W + INSTR_W;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] w_rd_entry;
    logic               w_push_fire;
    logic               w_pop_fire;
    logic               w_bypass;
    logic               w_we;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count      = wr_ptr_q - rd_ptr_q;
    assign push_ready = !full && !rst;

`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
    assign w_bypass = empty && push_valid && !flush && !rst;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push_fire = push_valid && push_ready;
    // Pops only move rd_ptr when the head actually lives in storage.
    assign w_pop_fire  = !empty && pop_ready;
    assign w_we        = w_push_fire && !flush && !(w_bypass && pop_ready);
    assign pop_valid   = !empty || w_bypass;

    always_comb begin
        pop_pc    = '0;
        pop_instr = INSTR_W'(INSTR_NOP);
        if (!empty) begin
            pop_pc    = w_rd_entry[ENTRY_W-1:INSTR_W];
            pop_instr = w_rd_entry[INSTR_W-1:0];
        end else if (w_bypass) begin
            pop_pc    = push_pc;
            pop_instr = push_instr;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_we) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    iq_regfile #(
        .DEPTH   (DEPTH),
        .ENTRY_T (logic [ENTRY_W-1:0])
    ) u_regfile (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({push_pc, push_instr}),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (w_rd_entry)
    );

endmodule : instr_fetch_queue

`default_nettype wire
